// File: rtl/nn_grad_ss_gen_2ch_pkg.sv
// nn_grad_ss_gen_2ch_pkg: state encoding and LFSR constants shared by the stochastic gradient generator.
package nn_grad_ss_gen_2ch_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} stateT;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;
   function automatic logic [7:0] bitRev8(input logic [7:0] v);
      for (int i = 0; i < 8; i++) bitRev8[i] = v[7-i];
   endfunction
endpackage

// File: rtl/nn_grad_ss_gen_2ch_lfsr.sv
// nn_lfsr8: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing only when ADV is high.
module nn_lfsr8
   import nn_grad_ss_gen_2ch_pkg::*;
#(
   parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
   input  logic       CLK,
   input  logic       INIT,
   input  logic       ADV,
   output logic [7:0] Q
);
   always_ff @(posedge CLK or posedge INIT)
      if (INIT) Q <= SEED;
      else if (ADV) Q <= {Q[6:0], ^(Q & LFSR_TAPS)};
endmodule

// File: rtl/nn_grad_ss_gen_2ch.sv
// nn_grad_ss_gen_2ch: two-channel stochastic bitstream burst generator; NN_GRAD_DEADZONE_EN zeroes sub-threshold gradients at latch time.
module nn_grad_ss_gen_2ch
   import nn_grad_ss_gen_2ch_pkg::*;
#(
   parameter int           N         = 8,
   parameter int           N_BURST   = 10,
   parameter logic [7:0]   LFSR_SEED = LFSR_SEED_DEF,
   parameter logic [N-1:0] DEADZONE  = 8'd4
) (
   input  logic               CLK,
   input  logic               INIT,
   input  logic               START,
   input  logic [N-1:0]       GRAD0,
   input  logic [N-1:0]       GRAD1,
   input  logic [1:0]         GRAD_SIGN,
   input  logic [N_BURST-1:0] BURST_LEN,
   output logic [1:0]         IN_SS,
   output logic [1:0]         SIGN,
   output logic               regIndex,
   output logic               EN,
   output logic               BUSY,
   output logic               DONE
);
`ifdef NN_GRAD_DEADZONE_EN
   localparam bit DZ_ON = 1'b1;
`else
   localparam bit DZ_ON = 1'b0;
`endif
   stateT state, nextState;
   logic [N-1:0] g0, g1;
   logic [1:0] s;
   logic [N_BURST-1:0] cnt;
   logic [7:0] lfsrQ;
   logic run, dead0, dead1, startOk;
   assign run = state == RUN;
   assign startOk = state == IDLE && START;
   assign dead0 = DZ_ON && GRAD0 < DEADZONE;
   assign dead1 = DZ_ON && GRAD1 < DEADZONE;
   nn_lfsr8 #(.SEED(LFSR_SEED)) lfsr (.CLK(CLK), .INIT(INIT), .ADV(run), .Q(lfsrQ));
   always_ff @(posedge CLK or posedge INIT)
      if (INIT) state <= IDLE;
      else state <= nextState;
   always_comb begin
      nextState = IDLE;
      nextState = state == IDLE ? (START ? (BURST_LEN == '0 ? FIN : RUN) : IDLE)
                : run ? ((regIndex && cnt == N_BURST'(1)) ? FIN : RUN)
                : IDLE;
   end
   // the counter counts channel pairs, so it only steps on the channel-1 half
   always_ff @(posedge CLK or posedge INIT)
      if (INIT) begin
         g0 <= '0;
         g1 <= '0;
         s <= '0;
         cnt <= '0;
         regIndex <= 1'b0;
      end else begin
         regIndex <= run & ~regIndex;
         if (startOk) begin
            g0 <= dead0 ? '0 : GRAD0;
            g1 <= dead1 ? '0 : GRAD1;
            s <= GRAD_SIGN & ~{dead1, dead0};
            cnt <= BURST_LEN;
         end else if (run && regIndex) cnt <= cnt - N_BURST'(1);
      end
   assign EN = run;
   assign BUSY = state != IDLE;
   assign DONE = state == FIN;
   assign SIGN = BUSY ? s : 2'b00;
   assign IN_SS = run ? {g1 >= bitRev8(lfsrQ), g0 >= lfsrQ} : 2'b00;
endmodule

// File: tb/tb_nn_grad_ss_gen_2ch.sv
// tb_nn_grad_ss_gen_2ch: directed self-checking bench for nn_grad_ss_gen_2ch.
module tb_nn_grad_ss_gen_2ch;
`ifdef NN_GRAD_DEADZONE_EN
   localparam bit DZ = 1'b1;
`else
   localparam bit DZ = 1'b0;
`endif
   logic CLK = 1'b0, INIT = 1'b0, START = 1'b0;
   logic [7:0] GRAD0 = '0, GRAD1 = '0;
   logic [1:0] GRAD_SIGN = '0;
   logic [9:0] BURST_LEN = '0;
   logic [1:0] IN_SS, SIGN;
   logic regIndex, EN, BUSY, DONE;
   logic [7:0] outs, mL;
   int nCmp = 0, nErr = 0, ones0 = 0, ones1 = 0, diff = 0;
   assign outs = {IN_SS, SIGN, regIndex, EN, BUSY, DONE};
   nn_grad_ss_gen_2ch dut (
      .CLK(CLK), .INIT(INIT), .START(START), .GRAD0(GRAD0), .GRAD1(GRAD1),
      .GRAD_SIGN(GRAD_SIGN), .BURST_LEN(BURST_LEN), .IN_SS(IN_SS), .SIGN(SIGN),
      .regIndex(regIndex), .EN(EN), .BUSY(BUSY), .DONE(DONE)
   );
   always #5 CLK = ~CLK;
   function automatic logic [7:0] nxt(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction
   function automatic logic [7:0] rev(input logic [7:0] q);
      for (int i = 0; i < 8; i++) rev[i] = q[7-i];
   endfunction
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic burst(input logic [7:0] g0, input logic [7:0] g1, input logic [1:0] sg,
                        input logic [9:0] len, input bit hold);
      logic [7:0] eg0, eg1;
      logic [1:0] es;
      logic b0;
      int cyc;
      eg0 = (DZ && g0 < 8'd4) ? 8'd0 : g0;
      eg1 = (DZ && g1 < 8'd4) ? 8'd0 : g1;
      es = sg & ~{DZ && g1 < 8'd4, DZ && g0 < 8'd4};
      GRAD0 = g0; GRAD1 = g1; GRAD_SIGN = sg; BURST_LEN = len; START = 1'b1;
      tick();
      START = hold; GRAD0 = ~g0; GRAD1 = ~g1; GRAD_SIGN = ~sg; BURST_LEN = len + 10'd3;
      ones0 = 0; ones1 = 0; diff = 0; cyc = 0; b0 = 1'b0;
      while (!DONE && cyc <= 2 * int'(len)) begin
         chk("run_en", EN, 1);
         chk("run_regIndex", regIndex, cyc[0]);
         chk("run_sign", SIGN, es);
         chk("run_in_ss", IN_SS, {eg1 >= rev(mL), eg0 >= mL});
         if (!cyc[0]) begin
            ones0 += IN_SS[0];
            b0 = IN_SS[0];
         end else begin
            ones1 += IN_SS[1];
            diff += int'(IN_SS[1] != b0);
         end
         mL = nxt(mL);
         cyc++;
         tick();
      end
      START = 1'b0;
      chk("run_len", cyc, 2 * int'(len));
      chk("fin_done", DONE, 1);
      chk("fin_busy", BUSY, 1);
      chk("fin_en", EN, 0);
      chk("fin_sign", SIGN, es);
      tick();
      chk("idle_after", outs, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      #2 INIT = 1'b1;
      #1;
      chk("rst_outs", outs, 0);
      chk("rst_lfsr", dut.lfsrQ, 8'hA5);
      mL = 8'hA5;
      tick();
      tick();
      INIT = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_outs", outs, 0);
         chk("idle_lfsr", dut.lfsrQ, 8'hA5);
      end
      burst(8'd255, 8'd0, 2'b10, 10'd4, 1'b0);
      burst(8'd0, 8'd0, 2'b01, 10'd0, 1'b0);
      burst(8'd90, 8'd170, 2'b11, 10'd3, 1'b1);
      burst(8'd128, 8'd128, 2'b00, 10'd255, 1'b0);
      chk("dens_ch0", ones0 >= 127 && ones0 <= 129, 1);
      chk("dens_ch1", ones1 >= 127 && ones1 <= 129, 1);
      chk("dens_decorrelated", diff > 0, 1);
      GRAD0 = 8'd255; GRAD1 = 8'd255; GRAD_SIGN = 2'b11; BURST_LEN = 10'd4; START = 1'b1;
      tick();
      START = 1'b0;
      tick();
      tick();
      chk("abort_pre_en", EN, 1);
      INIT = 1'b1;
      #1;
      chk("abort_outs", outs, 0);
      chk("abort_lfsr", dut.lfsrQ, 8'hA5);
      mL = 8'hA5;
      repeat (3) begin
         tick();
         chk("abort_no_done", DONE, 0);
      end
      INIT = 1'b0;
      tick();
      chk("abort_idle", outs, 0);
      burst(8'd200, 8'd60, 2'b11, 10'd4, 1'b0);
      burst(8'd3, 8'd0, 2'b01, DZ ? 10'd8 : 10'd255, 1'b0);
      chk("dz_ones0", ones0, DZ ? 0 : 3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end
endmodule

// File: doc/nn_grad_ss_gen_2ch.md
Name: nn_grad_ss_gen_2ch

Overview:
- Upstream stimulus stage for the 2-channel polar smooth-gradient accumulator.
- Converts two latched sign-magnitude gradients into stochastic bitstreams, one per channel, over a bounded burst.
- Produces the time-multiplexed channel index, the enable, and per-channel sign for that accumulator.
- A START/BUSY/DONE handshake lets the training controller request one burst per update.

Parameters:
- N, 8, gradient magnitude width. Must equal the LFSR width; only 8 is supported.
- N_BURST, 10, burst-length counter width.
- LFSR_SEED, 8'hA5, LFSR reset value. Must be non-zero.
- DEADZONE, 8'd4, magnitude threshold; used only with the optional feature.

Ports:
- CLK  in  1  clock, rising edge.
- INIT  in  1  reset, asynchronous, active-high.
- START  in  1  request a burst; sampled only in IDLE.
- GRAD0  in  N  channel-0 gradient magnitude.
- GRAD1  in  N  channel-1 gradient magnitude.
- GRAD_SIGN  in  2  per-channel gradient sign; bit c belongs to channel c.
- BURST_LEN  in  N_BURST  number of channel pairs per burst.
- IN_SS  out  2  stochastic bit per channel.
- SIGN  out  2  per-channel sign, held for the whole burst.
- regIndex  out  1  channel currently served by the downstream accumulator.
- EN  out  1  downstream accumulate enable.
- BUSY  out  1  high whenever state is not IDLE.
- DONE  out  1  one-cycle pulse at end of burst.

Behaviour:
- Reset (INIT high), asynchronous:
  - state = IDLE; LFSR = LFSR_SEED; pair counter = 0.
  - Gradient latches g0, g1 = 0; sign latch s = 0; regIndex = 0.
  - EN, BUSY, DONE, IN_SS, SIGN all = 0.
- INIT asserted mid-burst aborts immediately. No DONE is issued.
- States: IDLE, RUN, FIN.
- IDLE:
  - If START=1 at a clock edge: latch g0=GRAD0, g1=GRAD1, s=GRAD_SIGN, counter=BURST_LEN.
  - Next state is RUN, or FIN if BURST_LEN==0.
  - START in any other state is ignored. No queuing.
- RUN, entered one cycle after the START edge:
  - EN=1.
  - regIndex toggles every cycle, starting at 0. The first RUN cycle serves channel 0.
  - The LFSR advances every RUN cycle. It is an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, range 1..255, period 255.
  - On each regIndex==1 cycle the counter decrements. When it reaches 0 on that cycle, the next state is FIN.
  - RUN therefore lasts exactly 2*BURST_LEN cycles.
- FIN: DONE=1 and BUSY=1 for one cycle, then IDLE.
- Stochastic bits are combinational from registers:
  - IN_SS[0] = (g0 >= L). IN_SS[1] = (g1 >= bitrev(L)), where L is the current LFSR value.
  - The bit-reversed view decorrelates the two channels.
  - IN_SS is forced to 0 outside RUN.
  - Exactness: g=0 gives all zeros; g=255 gives all ones; otherwise density is g/255 over a full LFSR period.
- SIGN = s during RUN and FIN, 0 in IDLE.
- Magnitude changes on GRAD0/GRAD1/GRAD_SIGN after the START edge have no effect until the next burst.
- BURST_LEN = 2^N_BURST − 1 is legal; there is no wrap, and the counter only decrements from the loaded value.
- The LFSR is not reseeded between bursts. Its state carries over so successive bursts use fresh sequences.

Optional Feature:
- Macro: NN_GRAD_DEADZONE_EN.
- With the macro defined: at latch time, any magnitude < DEADZONE is stored as 0, and the corresponding sign is stored as 0. Small-gradient jitter therefore produces no accumulator activity.
- Without the macro: magnitudes and signs are latched unmodified. DEADZONE is unused.

Decomposition:
- Shared package:
  - State encoding typedef (IDLE=2'd0, RUN=2'd1, FIN=2'd2).
  - LFSR tap-mask constant.
  - Default LFSR_SEED constant.
- One natural sub-module: nn_lfsr8. Inputs CLK, INIT, advance enable, seed parameter; output is the 8-bit state.
- The comparators, counter and FSM stay in the top module.

Test Plan:
- Reset/idle: INIT pulse, then idle 10 cycles. Required: all outputs 0 and LFSR == 8'hA5 throughout.
- Basic burst: GRAD0=255, GRAD1=0, GRAD_SIGN=2'b10, BURST_LEN=4, START for 1 cycle. Required:
  - EN high exactly 8 cycles; regIndex sequence 0,1,0,1,0,1,0,1.
  - IN_SS[0]=1 and IN_SS[1]=0 every RUN cycle; SIGN=2'b10.
  - DONE pulses on cycle 9 after START; BUSY low on cycle 10.
- Density: GRAD0=GRAD1=128, BURST_LEN=255. Required: count of IN_SS[0] ones over channel-0 RUN cycles = 128 ±1, same for channel 1; the two channels' bit sequences are not identical.
- Zero-length and ignore: START with BURST_LEN=0 → EN never high, DONE one cycle later. START re-asserted during RUN → burst length unchanged, no second burst.
- Abort: INIT asserted at RUN cycle 3 → all outputs 0 asynchronously, no DONE; next START runs a full burst normally.
- Deadzone, with NN_GRAD_DEADZONE_EN defined: GRAD0=3, GRAD_SIGN[0]=1, BURST_LEN=8 → IN_SS[0]=0 and SIGN[0]=0 throughout. Without the macro: SIGN[0]=1 and some IN_SS[0] ones across a 255-pair burst.
